// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential 32x32 multiply/divide unit.
package muldiv_pkg;

  localparam int ITER_COUNT = 32;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic [63:0] acc_i,
  input  logic [31:0] opnd_i,
  input  logic        div_i,
  output logic [63:0] acc_o
);

  logic [32:0] sum;
  logic [32:0] diff;

  always_comb begin
    sum   = {1'b0, acc_i[63:32]} + {1'b0, opnd_i};
    // Shifted partial remainder is 33 bits wide; its borrow decides restore vs keep.
    diff  = acc_i[63:31] - {1'b0, opnd_i};
    acc_o = '0;
    if (div_i) begin
      acc_o = diff[32] ? {acc_i[62:0], 1'b0} : {diff[31:0], acc_i[30:0], 1'b1};
    end else begin
      acc_o = acc_i[0] ? {sum, acc_i[31:1]} : {1'b0, acc_i[63:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential signed/unsigned 32-bit multiply/divide, 32 radix-2 iterations per op.
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        Done,
  output logic        DivZero,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d, nrem_q, nrem_d, dz_q, dz_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        is_div, is_signed;
  logic [63:0] step_acc, prod;

  assign is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);

  // b_q holds the per-iteration operand magnitude once PREP has run.
  muldiv_step u_step (
    .acc_i  (acc_q),
    .opnd_i (b_q),
    .div_i  (is_div),
    .acc_o  (step_acc)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    nrem_d  = nrem_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    prod    = neg_q ? -acc_q : acc_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          a_d     = A;
          b_d     = B;
          op_d    = op_e'(Op);
          state_d = PREP;
        end
      end
      PREP: begin
        cnt_d  = '0;
        neg_d  = is_signed && (a_q[31] ^ b_q[31]);
        nrem_d = is_signed && a_q[31];
        dz_d   = is_div && (b_q == '0);
        if (is_div) begin
          acc_d = {32'd0, mag32(a_q, is_signed)};
          b_d   = mag32(b_q, is_signed);
        end else begin
          acc_d = {32'd0, mag32(b_q, is_signed)};
          b_d   = mag32(a_q, is_signed);
        end
        state_d = (is_div && (b_q == '0)) ? DONE : ITER;
      end
      ITER: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(ITER_COUNT - 1)) state_d = FIX;
      end
      FIX: begin
        if (is_div) begin
          lo_d = neg_q  ? -acc_q[31:0]  : acc_q[31:0];
          hi_d = nrem_q ? -acc_q[63:32] : acc_q[63:32];
        end else begin
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      nrem_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      nrem_q  <= nrem_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Busy    = (state_q != IDLE);
  assign Done    = (state_q == DONE);
  assign DivZero = Done && dz_q;
  assign Hi      = hi_q;
  assign Lo      = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed plus random checks of muldiv_seq against an arithmetic reference model.
module tb_muldiv_seq;

  logic        Clk = 1'b0, Reset = 1'b0, Start = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [31:0] A = '0, B = '0;
  logic        Busy, Done, DivZero;
  logic [31:0] Hi, Lo;

  int          n_cmp = 0, n_err = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  always #5 Clk = ~Clk;

  muldiv_seq dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .Op      (Op),
    .A       (A),
    .B       (B),
    .Busy    (Busy),
    .Done    (Done),
    .DivZero (DivZero),
    .Hi      (Hi),
    .Lo      (Lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV integer division truncates toward zero.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el,
                       output logic edz, output int lat);
    longint sa, sb, p, q, r;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    edz = 1'b0; lat = 35; eh = m_hi; el = m_lo;
    case (op)
      2'b00: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
      2'b01: begin up = {32'd0, a} * {32'd0, b}; eh = up[63:32]; el = up[31:0]; end
      2'b10: if (b == 0) begin edz = 1'b1; lat = 2; end
             else begin q = sa / sb; r = sa % sb; eh = r[31:0]; el = q[31:0]; end
      default: if (b == 0) begin edz = 1'b1; lat = 2; end
               else begin el = a / b; eh = a % b; end
    endcase
  endtask

  // Called at a negedge in an IDLE cycle; returns at the negedge of the following IDLE cycle.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string tag, input bit repulse);
    logic [31:0] eh, el;
    logic        edz;
    int          lat, cyc;
    model(op, a, b, eh, el, edz, lat);
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge Clk);
    Start = 1'b0; A = $urandom; B = $urandom; Op = 2'($urandom);
    chk({tag, " busy"}, 64'(Busy), 64'd1);
    cyc = 1;
    while (!Done && cyc < 60) begin
      Start = repulse && (cyc == 5);
      @(negedge Clk);
      cyc++;
    end
    Start = 1'b0;
    chk({tag, " lat"}, 64'(cyc), 64'(lat));
    chk({tag, " hi"}, 64'(Hi), 64'(eh));
    chk({tag, " lo"}, 64'(Lo), 64'(el));
    chk({tag, " divzero"}, 64'(DivZero), 64'(edz));
    m_hi = eh; m_lo = el;
    @(negedge Clk);
    chk({tag, " done pulse"}, {62'd0, Done, Busy}, 64'd0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    bit          saw_done;

    repeat (2) @(negedge Clk);
    chk("reset outputs", {Busy, Done, DivZero, Hi, Lo}, 64'd0);
    Reset = 1'b1;

    do_op(2'b00, 32'd7, 32'hFFFFFFFD, "mult 7x-3", 1'b0);
    chk("mult 7x-3 held", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFEB);
    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu max", 1'b0);
    chk("multu max held", {Hi, Lo}, 64'hFFFFFFFE_00000001);
    do_op(2'b10, 32'hFFFFFFF9, 32'd2, "div -7/2", 1'b0);
    chk("div -7/2 held", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFFD);
    do_op(2'b11, 32'hFFFFFFF9, 32'd2, "divu", 1'b0);
    chk("divu held", {Hi, Lo}, 64'h00000001_7FFFFFFC);
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, "div ovf", 1'b0);
    chk("div ovf held", {Hi, Lo}, 64'h00000000_80000000);
    do_op(2'b11, 32'h2211, 32'h100, "divu setup", 1'b0);
    do_op(2'b11, 32'h1234, 32'd0, "divu by0", 1'b0);
    chk("divu by0 held", {Hi, Lo}, 64'h00000011_00000022);
    do_op(2'b10, 32'h8000_0000, 32'd0, "div by0", 1'b0);

    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) ra = {{28{ra[31]}}, ra[3:0]};
      do_op(rop, ra, rb, $sformatf("rand%0d op%0d", i, rop), 1'b0);
    end

    do_op(2'b01, 32'h0001_0003, 32'h0000_0005, "repulse", 1'b1);

    Start = 1'b1; Op = 2'b00; A = 32'h1234_5678; B = 32'h9ABC_DEF0;
    @(negedge Clk);
    Start = 1'b0;
    repeat (9) @(negedge Clk);
    Reset = 1'b0;
    #1;
    chk("midop reset", {Busy, Done, DivZero, Hi, Lo}, 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge Clk);
    Reset = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      if (Done) saw_done = 1'b1;
    end
    chk("no done after reset", 64'(saw_done), 64'd0);
    do_op(2'b10, 32'd100, 32'hFFFFFFF9, "after reset", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
